// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, line/frame total helpers and sync polarities.
package vga_timing_pkg;
  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;
  localparam int H_DISP_640 = 640;
  localparam int H_FP_640 = 16;
  localparam int H_SYNC_640 = 96;
  localparam int H_BP_640 = 48;
  localparam int V_DISP_480 = 480;
  localparam int V_FP_480 = 10;
  localparam int V_SYNC_480 = 2;
  localparam int V_BP_480 = 33;
  function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction
  function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_prescaler.sv
// vga_prescaler: one-clk tick every DIV enabled clk cycles; the count freezes while en is low.
module vga_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  logic [PW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (en) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
  end
  assign tick = en && cnt == LAST;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (sync, video_on, coordinates, strobes).
// Define VGA_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int   CW     = 11,
  parameter int   DIV    = 4,
  parameter int   H_DISP = H_DISP_640,
  parameter int   H_FP   = H_FP_640,
  parameter int   H_SYNC = H_SYNC_640,
  parameter int   H_BP   = H_BP_640,
  parameter int   V_DISP = V_DISP_480,
  parameter int   V_FP   = V_FP_480,
  parameter int   V_SYNC = V_SYNC_480,
  parameter int   V_BP   = V_BP_480,
  parameter logic H_POL  = POL_NEG,
  parameter logic V_POL  = POL_NEG,
  parameter int   FCW    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  output logic           p_tick,
  output logic [CW-1:0]  pixel_x,
  output logic [CW-1:0]  pixel_y,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);
  localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_DISP);
  localparam logic [CW-1:0] V_ACT  = CW'(V_DISP);
  localparam logic [CW-1:0] HS_BEG = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_DISP + V_FP + V_SYNC - 1);
  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW || DIV < 1 || DIV > 16 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end
  logic h_last, v_last;
  logic [CW-1:0] h_nxt, v_nxt;
  vga_prescaler #(.DIV(DIV)) u_prescaler (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .tick(p_tick)
  );
  assign h_last      = pixel_x == H_LAST;
  assign v_last      = pixel_y == V_LAST;
  assign line_start  = p_tick && pixel_x == '0;
  assign frame_start = line_start && pixel_y == '0;
  always_comb begin
    h_nxt = p_tick ? (h_last ? '0 : pixel_x + 1'b1) : pixel_x;
    v_nxt = p_tick && h_last ? (v_last ? '0 : pixel_y + 1'b1) : pixel_y;
  end
  // Sync and blanking come from the next-state position so they switch with the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= ~H_POL;
      vsync    <= ~V_POL;
      video_on <= 1'b1;
    end else begin
      pixel_x  <= h_nxt;
      pixel_y  <= v_nxt;
      hsync    <= h_nxt >= HS_BEG && h_nxt <= HS_END ? H_POL : ~H_POL;
      vsync    <= v_nxt >= VS_BEG && v_nxt <= VS_END ? V_POL : ~V_POL;
      video_on <= h_nxt < H_ACT && v_nxt < V_ACT;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_cnt <= '0;
    else if (p_tick && h_last && v_last) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus corner-case sequences for vga_timing_gen.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC1 = 1;
`else
  localparam int FC1 = 0;
`endif
  typedef struct {
    int   cyc;
    logic tk, ls, fs;
    int   x, y;
    logic hs, vs, vo;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b1;
  logic p_tick0, hsync0, vsync0, video_on0, line_start0, frame_start0;
  logic p_tick1, hsync1, vsync1, video_on1, line_start1, frame_start1;
  logic p_tick2, hsync2, vsync2, video_on2, line_start2, frame_start2;
  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic [7:0] fc0, fc1, fc2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  vga_timing_gen dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .p_tick(p_tick0), .pixel_x(x0), .pixel_y(y0),
    .hsync(hsync0), .vsync(vsync0), .video_on(video_on0), .line_start(line_start0),
    .frame_start(frame_start0), .frame_cnt(fc0)
  );
  vga_timing_gen #(
    .DIV(1), .H_DISP(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_DISP(720), .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .p_tick(p_tick1), .pixel_x(x1), .pixel_y(y1),
    .hsync(hsync1), .vsync(vsync1), .video_on(video_on1), .line_start(line_start1),
    .frame_start(frame_start1), .frame_cnt(fc1)
  );
  vga_timing_gen #(
    .DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .p_tick(p_tick2), .pixel_x(x2), .pixel_y(y2),
    .hsync(hsync2), .vsync(vsync2), .video_on(video_on2), .line_start(line_start2),
    .frame_start(frame_start2), .frame_cnt(fc2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    vec_t tbl[14];
    int idx, hs_low, bad, hmin, hmax, fs_cnt, vs_low;
    logic [27:0] snap;
    tbl[0]  = '{0,    1'b0, 1'b0, 1'b0, 0,   0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    1'b0, 1'b0, 1'b0, 0,   0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{3,    1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{4,    1'b0, 1'b0, 1'b0, 1,   0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{7,    1'b1, 1'b0, 1'b0, 1,   0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{2559, 1'b1, 1'b0, 1'b0, 639, 0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{2560, 1'b0, 1'b0, 1'b0, 640, 0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2623, 1'b1, 1'b0, 1'b0, 655, 0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2624, 1'b0, 1'b0, 1'b0, 656, 0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{3004, 1'b0, 1'b0, 1'b0, 751, 0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3008, 1'b0, 1'b0, 1'b0, 752, 0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{3199, 1'b1, 1'b0, 1'b0, 799, 0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{3200, 1'b0, 1'b0, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{3203, 1'b1, 1'b1, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1};
    // reset values while reset_n is held low
    @(negedge clk);
    chk("reset_vals", {p_tick0, line_start0, frame_start0, x0, y0, hsync0, vsync0, video_on0},
        {3'b000, 11'd0, 11'd0, 3'b111});
    chk("reset_fcnt", fc0, 0);
    // default timing: first tick and line wrap
    do_reset();
    idx = 0;
    hs_low = 0;
    for (int c = 0; c <= 3203; c++) begin
      if (c > 0) @(negedge clk);
      if (p_tick0 && !hsync0 && y0 == 0) hs_low++;
      if (idx < 14 && tbl[idx].cyc == c) begin
        chk($sformatf("vec%0d_cyc%0d", idx, c),
            {p_tick0, line_start0, frame_start0, x0, y0, hsync0, vsync0, video_on0},
            {tbl[idx].tk, tbl[idx].ls, tbl[idx].fs, 11'(tbl[idx].x), 11'(tbl[idx].y),
             tbl[idx].hs, tbl[idx].vs, tbl[idx].vo});
        idx++;
      end
    end
    chk("table_done", idx, 14);
    chk("hsync_low_ticks", hs_low, 96);
    // en held low for 37 clks mid-line with the prescaler at phase 1
    do_reset();
    repeat (1201) @(negedge clk);
    chk("hold_pre_x", {p_tick0, x0}, {1'b0, 11'd300});
    snap = {p_tick0, line_start0, frame_start0, x0, y0, hsync0, vsync0, video_on0};
    en = 1'b0;
    bad = 0;
    repeat (37) begin
      @(negedge clk);
      if ({p_tick0, line_start0, frame_start0, x0, y0, hsync0, vsync0, video_on0} !== snap) bad++;
    end
    chk("hold_stable", bad, 0);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume_tick", {p_tick0, x0}, {1'b1, 11'd300});
    @(negedge clk);
    chk("resume_x", {p_tick0, x0}, {1'b0, 11'd301});
    // 1280x720, DIV=1, positive sync
    do_reset();
    bad = 0;
    hs_low = 0;
    hmin = 9999;
    hmax = -1;
    for (int c = 0; c <= 1650; c++) begin
      if (c > 0) @(negedge clk);
      if (!p_tick1) bad++;
      if (hsync1) begin
        hs_low++;
        if (int'(x1) < hmin) hmin = int'(x1);
        if (int'(x1) > hmax) hmax = int'(x1);
      end
      if (c == 0) chk("alt_start", {frame_start1, vsync1, video_on1}, 3'b101);
      if (c == 1280) chk("alt_blank", {x1, video_on1}, {11'd1280, 1'b0});
      if (c == 1649) chk("alt_last", {x1, y1}, {11'd1649, 11'd0});
      if (c == 1650) chk("alt_wrap", {x1, y1, line_start1}, {11'd0, 11'd1, 1'b1});
    end
    chk("alt_tick_always", bad, 0);
    chk("alt_hsync_width", hs_low, 40);
    chk("alt_hsync_range", {hmin[15:0], hmax[15:0]}, {16'd1390, 16'd1429});
    // small frame (14x8, DIV=2): frame wrap, vsync lines, frame counter
    do_reset();
    bad = 0;
    fs_cnt = 0;
    vs_low = 0;
    for (int c = 0; c <= 226; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2 && frame_start2) fs_cnt++;
      if (p_tick2 && !vsync2) vs_low++;
      if (!vsync2 && !(y2 == 5 || y2 == 6)) bad++;
      if (c == 223) chk("frm_last", {p_tick2, x2, y2, fc2}, {1'b1, 11'd13, 11'd7, 8'd0});
      if (c == 224) chk("frm_wrap", {x2, y2, fc2}, {11'd0, 11'd0, 8'(FC1)});
    end
    chk("frm_start_once", fs_cnt, 1);
    chk("vsync_ticks", vs_low, 28);
    chk("vsync_lines", bad, 0);
    // asynchronous reset between clk edges mid-frame
    do_reset();
    repeat (79) @(negedge clk);
    chk("pre_areset", {p_tick2, x2, y2, hsync2, video_on2}, {1'b1, 11'd11, 11'd2, 2'b00});
    #2 reset_n = 1'b0;
    #1;
    chk("areset_vals", {p_tick2, line_start2, frame_start2, x2, y2, hsync2, vsync2, video_on2},
        {3'b000, 11'd0, 11'd0, 3'b111});
    chk("areset_fcnt", fc2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path. It divides the system clock into a pixel-rate enable and runs mod-H_TOTAL and mod-V_TOTAL position counters. From those counters it drives polarity-configurable hsync/vsync, video_on, pixel coordinates and line/frame strobes. It sits between the board clock and the pixel/colour generators and replaces the fixed 640x480 divide-by-4 sync block.

## Interface
- `CW`, 11: width of the position counters and of pixel_x/pixel_y.
- `DIV`, 4: clk cycles per pixel; legal range 1..16.
- `H_DISP`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 1'b0: asserted level of hsync (0 = negative sync).
- `V_POL`, 1'b0: asserted level of vsync.
- `FCW`, 8: frame counter width.
- `clk` in 1: system clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. When low, the prescaler, counters and all outputs hold.
- `p_tick` out 1: pixel enable. One clk wide, once every DIV clks.
- `pixel_x` out CW: current horizontal position.
- `pixel_y` out CW: current vertical position.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `video_on` out 1: high when the current position is in the active area.
- `line_start` out 1: one-clk strobe at the start of each line.
- `frame_start` out 1: one-clk strobe at the start of each frame.
- `frame_cnt` out FCW: frame counter (see Configuration).

## Operation
- Totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (default 525).
- Elaboration error if H_TOTAL > 2**CW, V_TOTAL > 2**CW, DIV = 0, or any sync width = 0.
- Prescaler:
  - Counts 0..DIV-1 while `en`=1.
  - `p_tick` = `en` && (prescaler == DIV-1).
  - With DIV=1, `p_tick` = `en`.
- Horizontal counter:
  - Advances on every clk edge where `p_tick`=1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Advances on a `p_tick` edge where the horizontal counter is at H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0 at that same edge.
- Line order: display, front porch, sync, back porch. Frame order is the same.
- hsync is asserted (= H_POL) for h in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] (default 656..751); otherwise it is ~H_POL.
- vsync is asserted (= V_POL) for v in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] (default 490..491); otherwise it is ~V_POL.
- `video_on` = (h < H_DISP) && (v < V_DISP).
- `line_start` = `p_tick` && h==0.
- `frame_start` = `p_tick` && h==0 && v==0.
- `en` deasserted mid-line: the prescaler freezes at its current value; no position is skipped or repeated on resume.

## Timing
- `pixel_x`/`pixel_y` are the counter registers.
- hsync, vsync and video_on are registered from next-state counter values, so they change on the same clk edge as `pixel_x`/`pixel_y` and are glitch-free.
- `p_tick`, `line_start` and `frame_start` are decoded combinationally from registers.
- Reset values:
  - prescaler 0, `pixel_x` 0, `pixel_y` 0.
  - hsync ~H_POL, vsync ~V_POL, `video_on` 1.
  - `frame_cnt` 0.
  - `p_tick`, `line_start` and `frame_start` are low.
- First `p_tick` is DIV-1 clks after reset release with `en`=1; `frame_start` is high in that cycle.
- Reset asserted mid-frame: everything returns asynchronously to the reset values; there is no partial-frame recovery.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on one edge, and `frame_cnt` increments on that same edge.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_cnt` increments modulo 2**FCW on every frame wrap edge (while `en`).
- Without the macro: `frame_cnt` is tied to 0 and no counter register is built. The port list is unchanged.

## Structure
- Shared package `vga_timing_pkg` holds:
  - default 640x480@60 timing constants.
  - H/V total derivation functions.
  - the sync-polarity localparams.
- Sub-module `vga_prescaler` (parameter DIV; ports `clk`, `reset_n`, `en`, `tick`). It is reused by other rate-enable consumers.

## Test plan
- **Reset and first tick:** release `reset_n` with `en`=1, defaults. Expect `p_tick`/`frame_start` first high at clk 3; outputs are at reset values before that.
- **Line wrap:** after 800 `p_tick`s, `pixel_x` 799→0 and `pixel_y` 0→1 on the same edge. hsync is low exactly for x 656..751 (96 ticks).
- **Frame wrap:** run 800×525 ticks. vsync is low only on lines 490..491. `frame_start` fires once; `frame_cnt` goes 0→1 with the macro and stays 0 without it.
- **`en` hold:** deassert `en` for 37 clks mid-line at x=300. All outputs hold. Resume gives x=301 after the remaining prescaler phase; no skipped positions.
- **Alternate config:** DIV=1, 1280x720 timing (110/40/220, 5/5/20), H_POL=V_POL=1. Expect totals 1650/750, positive hsync for x 1390..1429, and `p_tick` constantly high.
- **Async reset mid-frame:** assert `reset_n` at x=500,y=300 between clk edges. Outputs return to reset values immediately without waiting for a clk edge.
